instr_mem_prog: RTL and testbench
=================================

Name: instr_mem_prog

Overview:
- Parametrised instruction memory, the successor to the fixed 19-bit x 32 combinational instruction store.
- Adds a registered fetch port with a valid flag.
- Adds a chunked program-load port, driven by a small loader FSM, so the CPU program can be written at run time instead of only at elaboration.
- Sits between the PC/fetch stage and an external loader (UART/testbench).

Parameters:
- INSTR_W, 19, instruction width in bits.
- ADDR_W, 5, address width; depth is 2**ADDR_W (derived, not overridable).
- LOAD_W, 8, load chunk width; NCHUNK = ceil(INSTR_W/LOAD_W), 3 at defaults.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  read request.
- fetch_addr  in  ADDR_W  read address.
- fetch_ready  out  1  a fetch is accepted this cycle.
- instr_valid  out  1  instruction holds data for the fetch accepted last cycle.
- instruction  out  INSTR_W  fetched word.
- load_start  in  1  begin a program load.
- load_base  in  ADDR_W  first word address of the load.
- load_count  in  ADDR_W+1  number of words to load.
- load_valid  in  1  load_data is valid.
- load_data  in  LOAD_W  chunk, LSB chunk first.
- load_ready  out  1  loader accepts a chunk this cycle.
- load_busy  out  1  a load is in progress.
- load_done  out  1  one-cycle pulse when a load completes.
- load_err  out  1  one-cycle pulse when a load request is rejected.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - instruction=0; instr_valid, load_ready, load_busy, load_done and load_err are all 0.
  - Memory array is not reset. It is zero-initialised at time 0 and contents survive reset.
- Fetch:
  - fetch_ready=1 only in IDLE.
  - A fetch is accepted when fetch_req && fetch_ready. mem[fetch_addr] is registered into instruction, and instr_valid=1 on the next cycle (1-cycle latency).
  - With no accepted fetch, instr_valid=0 next cycle and instruction holds its last value.
- FSM states: IDLE, ASSEMBLE, WRITE, DONE.
- IDLE:
  - On load_start with 1 <= load_count <= 2**ADDR_W: ptr=load_base, remaining=load_count, chunk_idx=0, go to ASSEMBLE.
  - On load_start with load_count==0 or load_count > 2**ADDR_W: pulse load_err the next cycle and stay in IDLE.
- ASSEMBLE:
  - load_ready=1.
  - Each load_valid && load_ready places load_data at shift-register bit offset chunk_idx*LOAD_W, then chunk_idx++.
  - After chunk NCHUNK-1 the FSM goes to WRITE. Bits of the last chunk above INSTR_W are discarded.
- WRITE (1 cycle):
  - mem[ptr] <= assembled word; ptr = (ptr+1) mod 2**ADDR_W (wrap-around allowed); remaining--.
  - If remaining was 1, go to DONE; otherwise clear chunk_idx and go to ASSEMBLE.
- DONE (1 cycle): load_done=1, then return to IDLE.
- load_busy=1 in every state except IDLE.
- While busy, fetch_ready=0 and accepted fetches are impossible. instr_valid falls to 0 the cycle after the load starts.
- Simultaneous fetch_req and load_start in IDLE:
  - The fetch is accepted and returns the pre-load word next cycle.
  - The load starts in the same cycle.
- load_start while busy is ignored; no error pulse.
- Reset mid-load aborts the load. Words already written stay; the partially assembled word is dropped.
- A word written in WRITE is visible to a fetch in the following IDLE. There is no read-during-write path, because fetch is blocked while busy.

Decomposition:
- Shared package instr_mem_pkg holds:
  - the default INSTR_W, ADDR_W and LOAD_W constants;
  - the loader state encoding (IDLE=0, ASSEMBLE=1, WRITE=2, DONE=3);
  - opcode field position constants ([18:15]) for the bench decoder.
- One sub-module is natural: instr_load_fsm, containing the FSM, chunk assembler and pointer/counter. It outputs a write enable, write address and write data to the array in the top module.

Test Plan:
- Reset, then fetch addresses 0..31 with no load -> every instruction=0, each with instr_valid exactly 1 cycle after fetch_req; all outputs are 0 while rst_n=0.
- Load base=3, count=2, chunks 0x01,0x08,0x05,0x00,0x88,0x05:
  - load_done pulses once;
  - then fetch 3 -> 19'h50801 and fetch 4 -> 19'h58800;
  - fetch 2 and fetch 5 -> 0.
- Load base=31, count=2, words 19'h7FFFF and 19'h00001:
  - mem[31]=19'h7FFFF and mem[0]=19'h00001 (wrap);
  - the chunk 0xFF in the upper slot is truncated to 3 bits.
- load_count=0, then load_count=33 -> load_err pulses for 1 cycle each; load_busy stays 0; memory is unchanged.
- Fetch addr 3 asserted continuously while load_start rises:
  - the same-cycle fetch returns the old mem[3];
  - then fetch_ready=0 and instr_valid=0 until DONE;
  - fetch_ready returns the cycle after load_done.
- Assert rst_n=0 after 1 of 2 words has been written:
  - FSM returns to IDLE and load_busy=0;
  - the first word is retained and the second address is unchanged;
  - a new load afterwards completes normally.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared constants and loader state encoding for the programmable instruction memory.
package instr_mem_pkg;

    localparam int unsigned InstrW = 19;
    localparam int unsigned AddrW  = 5;
    localparam int unsigned LoadW  = 8;

    // Opcode field position inside an instruction word
    localparam int unsigned OpcodeMsb = 18;
    localparam int unsigned OpcodeLsb = 15;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StAssemble = 2'd1,
        StWrite    = 2'd2,
        StDone     = 2'd3
    } load_state_e;

endpackage

// File: rtl/instr_load_fsm.sv
// Program loader: assembles LOAD_W-bit chunks (LSB first) into words and emits array writes.
module instr_load_fsm
    import instr_mem_pkg::*;
#(
    parameter int unsigned INSTR_W = InstrW,
    parameter int unsigned ADDR_W  = AddrW,
    parameter int unsigned LOAD_W  = LoadW
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_start_i,
    input  logic [ADDR_W-1:0]  load_base_i,
    input  logic [ADDR_W:0]    load_count_i,
    input  logic               load_valid_i,
    input  logic [LOAD_W-1:0]  load_data_i,
    output logic               load_ready_o,
    output logic               load_busy_o,
    output logic               load_done_o,
    output logic               load_err_o,
    output logic               we_o,
    output logic [ADDR_W-1:0]  waddr_o,
    output logic [INSTR_W-1:0] wdata_o
);

    localparam int unsigned NChunk = (INSTR_W + LOAD_W - 1) / LOAD_W;
    localparam int unsigned ShW    = NChunk * LOAD_W;
    localparam int unsigned CIdxW  = (NChunk > 1) ? $clog2(NChunk) : 1;
    localparam logic [CIdxW-1:0] LastIdx  = CIdxW'(NChunk - 1);
    localparam logic [ADDR_W:0]  MaxCount = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  OneCount = {{ADDR_W{1'b0}}, 1'b1};

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [CIdxW-1:0]  idx_q, idx_d;
    logic [ShW-1:0]    shreg_q, shreg_d;
    logic [ShW-1:0]    shift_in;
    logic              err_q, err_d;

    // New chunks enter at the top; after NChunk shifts the first chunk sits at bit 0.
    if (NChunk > 1) begin : g_shift
        assign shift_in = {load_data_i, shreg_q[ShW-1:LOAD_W]};
    end else begin : g_single
        assign shift_in = load_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_start_i) begin
                    if (load_count_i == '0 || load_count_i > MaxCount) begin
                        err_d = 1'b1;
                    end else begin
                        ptr_d   = load_base_i;
                        rem_d   = load_count_i;
                        idx_d   = '0;
                        state_d = StAssemble;
                    end
                end
            end
            StAssemble: begin
                if (load_valid_i) begin
                    shreg_d = shift_in;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                ptr_d   = ptr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                idx_d   = '0;
                state_d = (rem_q == OneCount) ? StDone : StAssemble;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign load_ready_o = (state_q == StAssemble);
    assign load_busy_o  = (state_q != StIdle);
    assign load_done_o  = (state_q == StDone);
    assign load_err_o   = err_q;
    assign we_o         = (state_q == StWrite);
    assign waddr_o      = ptr_q;
    assign wdata_o      = shreg_q[INSTR_W-1:0];

endmodule

// File: rtl/instr_mem_prog.sv
// Run-time programmable instruction memory with a registered fetch port and chunked loader.
module instr_mem_prog
    import instr_mem_pkg::*;
#(
    parameter int unsigned INSTR_W = InstrW,
    parameter int unsigned ADDR_W  = AddrW,
    parameter int unsigned LOAD_W  = LoadW
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               fetch_req_i,
    input  logic [ADDR_W-1:0]  fetch_addr_i,
    output logic               fetch_ready_o,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instruction_o,
    input  logic               load_start_i,
    input  logic [ADDR_W-1:0]  load_base_i,
    input  logic [ADDR_W:0]    load_count_i,
    input  logic               load_valid_i,
    input  logic [LOAD_W-1:0]  load_data_i,
    output logic               load_ready_o,
    output logic               load_busy_o,
    output logic               load_done_o,
    output logic               load_err_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    // Array is zeroed at time 0 only; it deliberately has no reset so contents survive rst_ni.
    logic [INSTR_W-1:0] mem_q [Depth] = '{default: '0};

    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [INSTR_W-1:0] wdata;
    logic               fetch_accept;
    logic               instr_valid_q;
    logic [INSTR_W-1:0] instruction_q;

    instr_load_fsm #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W),
        .LOAD_W  (LOAD_W)
    ) u_load_fsm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_start_i (load_start_i),
        .load_base_i  (load_base_i),
        .load_count_i (load_count_i),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_ready_o (load_ready_o),
        .load_busy_o  (load_busy_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o),
        .we_o         (we),
        .waddr_o      (waddr),
        .wdata_o      (wdata)
    );

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Fetch is only open in idle, so reads never collide with loader writes.
    assign fetch_ready_o = !load_busy_o;
    assign fetch_accept  = fetch_req_i && fetch_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_valid_q <= 1'b0;
            instruction_q <= '0;
        end else begin
            instr_valid_q <= fetch_accept;
            if (fetch_accept) begin
                instruction_q <= mem_q[fetch_addr_i];
            end
        end
    end

    assign instr_valid_o = instr_valid_q;
    assign instruction_o = instruction_q;

endmodule

// File: tb/tb_instr_mem_prog.sv
// Scoreboard bench for instr_mem_prog: fetch sweep, loads, wrap, rejects, fetch/load overlap, reset abort.
module tb_instr_mem_prog;
    import instr_mem_pkg::*;

    localparam int unsigned IW = InstrW;
    localparam int unsigned AW = AddrW;
    localparam int unsigned LW = LoadW;
    localparam int unsigned NC = (IW + LW - 1) / LW;

    logic          clk;
    logic          rst_n;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ready;
    logic          instr_valid;
    logic [IW-1:0] instruction;
    logic          load_start;
    logic [AW-1:0] load_base;
    logic [AW:0]   load_count;
    logic          load_valid;
    logic [LW-1:0] load_data;
    logic          load_ready;
    logic          load_busy;
    logic          load_done;
    logic          load_err;

    int            n_checks;
    int            n_errors;
    logic [IW-1:0] exp_q[$];
    logic [LW-1:0] chunk_q[$];
    logic [IW-1:0] last_instr;

    instr_mem_prog #(
        .INSTR_W (IW),
        .ADDR_W  (AW),
        .LOAD_W  (LW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .fetch_req_i   (fetch_req),
        .fetch_addr_i  (fetch_addr),
        .fetch_ready_o (fetch_ready),
        .instr_valid_o (instr_valid),
        .instruction_o (instruction),
        .load_start_i  (load_start),
        .load_base_i   (load_base),
        .load_count_i  (load_count),
        .load_valid_i  (load_valid),
        .load_data_i   (load_data),
        .load_ready_o  (load_ready),
        .load_busy_o   (load_busy),
        .load_done_o   (load_done),
        .load_err_o    (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_compare(input string tag);
        logic [IW-1:0] e;
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, 32'(instruction), 32'(e));
            last_instr = e;
        end
    endtask

    task automatic push_word(input logic [IW-1:0] w);
        logic [31:0] t;
        t = 32'(w);
        for (int c = 0; c < NC; c++) chunk_q.push_back(t[c*LW +: LW]);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_instruction", 32'(instruction), 32'd0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_load_ready", 32'(load_ready), 32'd0);
        check_eq("rst_load_busy", 32'(load_busy), 32'd0);
        check_eq("rst_load_done", 32'(load_done), 32'd0);
        check_eq("rst_load_err", 32'(load_err), 32'd0);
    endtask

    task automatic fetch_word(input logic [AW-1:0] a, input logic [IW-1:0] e);
        fetch_req  = 1'b1;
        fetch_addr = a;
        check_eq("fetch_ready", 32'(fetch_ready), 32'd1);
        exp_q.push_back(e);
        step();
        fetch_req = 1'b0;
        check_eq("instr_valid", 32'(instr_valid), 32'd1);
        pop_compare("instruction");
        step();
        check_eq("valid_drop", 32'(instr_valid), 32'd0);
        check_eq("instr_hold", 32'(instruction), 32'(last_instr));
    endtask

    task automatic send_chunk(input logic [LW-1:0] d);
        int guard;
        guard      = 0;
        load_valid = 1'b1;
        load_data  = d;
        while (!load_ready && guard < 20) begin
            step();
            guard++;
        end
        check_eq("load_ready", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
        check_eq("valid_busy", 32'(instr_valid), 32'd0);
        check_eq("fready_busy", 32'(fetch_ready), 32'd0);
    endtask

    task automatic run_load(input logic [AW-1:0] base, input logic [AW:0] count);
        int guard;
        load_base  = base;
        load_count = count;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        if (exp_q.size() > 0) begin
            check_eq("valid_start", 32'(instr_valid), 32'd1);
            pop_compare("instr_start");
        end else begin
            check_eq("valid_start", 32'(instr_valid), 32'd0);
        end
        check_eq("busy_start", 32'(load_busy), 32'd1);
        check_eq("fready_start", 32'(fetch_ready), 32'd0);
        while (chunk_q.size() > 0) send_chunk(chunk_q.pop_front());
        guard = 0;
        while (!load_done && guard < 10) begin
            step();
            guard++;
        end
        check_eq("load_done", 32'(load_done), 32'd1);
        check_eq("fready_in_done", 32'(fetch_ready), 32'd0);
        step();
        check_eq("done_pulse", 32'(load_done), 32'd0);
        check_eq("busy_end", 32'(load_busy), 32'd0);
        check_eq("fready_end", 32'(fetch_ready), 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        last_instr = '0;
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_base  = '0;
        load_count = '0;
        load_valid = 1'b0;
        load_data  = '0;
        #2;
        check_reset_outputs();
        step();
        step();
        check_reset_outputs();
        rst_n = 1'b1;
        step();

        // Empty memory reads back zero everywhere
        for (int a = 0; a < 32; a++) fetch_word(AW'(a), '0);

        // Two-word load at base 3
        chunk_q = '{8'h01, 8'h08, 8'h05, 8'h00, 8'h88, 8'h05};
        run_load(5'd3, 6'd2);
        fetch_word(5'd3, 19'h50801);
        check_eq("opcode3", 32'(instruction[OpcodeMsb:OpcodeLsb]), 32'hA);
        fetch_word(5'd4, 19'h58800);
        fetch_word(5'd2, 19'h00000);
        fetch_word(5'd5, 19'h00000);

        // Wrap from 31 to 0, oversized top chunk truncated
        chunk_q = '{8'hFF, 8'hFF, 8'hFF};
        push_word(19'h00001);
        run_load(5'd31, 6'd2);
        fetch_word(5'd31, 19'h7FFFF);
        fetch_word(5'd0, 19'h00001);
        fetch_word(5'd1, 19'h00000);
        fetch_word(5'd30, 19'h00000);

        // Rejected counts
        for (int k = 0; k < 2; k++) begin
            load_count = (k == 0) ? 6'd0 : 6'd33;
            load_base  = 5'd7;
            load_start = 1'b1;
            step();
            load_start = 1'b0;
            check_eq("err_pulse", 32'(load_err), 32'd1);
            check_eq("err_busy", 32'(load_busy), 32'd0);
            step();
            check_eq("err_clear", 32'(load_err), 32'd0);
            check_eq("err_busy2", 32'(load_busy), 32'd0);
        end
        fetch_word(5'd3, 19'h50801);
        fetch_word(5'd7, 19'h00000);

        // Fetch held high while a load starts in the same cycle
        fetch_req  = 1'b1;
        fetch_addr = 5'd3;
        check_eq("overlap_fready", 32'(fetch_ready), 32'd1);
        exp_q.push_back(19'h50801);
        push_word(19'h12345);
        run_load(5'd10, 6'd1);
        exp_q.push_back(19'h50801);
        step();
        fetch_req = 1'b0;
        check_eq("resume_valid", 32'(instr_valid), 32'd1);
        pop_compare("resume_instr");
        step();
        fetch_word(5'd10, 19'h12345);

        // Reset after the first of two words is written
        load_base  = 5'd20;
        load_count = 6'd2;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        push_word(19'h2AAAA);
        while (chunk_q.size() > 0) send_chunk(chunk_q.pop_front());
        step();
        check_eq("abort_busy_pre", 32'(load_busy), 32'd1);
        send_chunk(8'h55);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        last_instr = '0;
        step();
        rst_n = 1'b1;
        step();
        check_eq("abort_idle", 32'(load_busy), 32'd0);
        fetch_word(5'd20, 19'h2AAAA);
        fetch_word(5'd21, 19'h00000);
        push_word(19'h15555);
        run_load(5'd21, 6'd1);
        fetch_word(5'd21, 19'h15555);
        fetch_word(5'd20, 19'h2AAAA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
